// File: rtl/pcie_phy_pkg.sv
// Shared PHY definitions: comma symbol default, alignment FSM encodings,
// and a helper that sizes counters to hold a given maximum value.
package pcie_phy_pkg;

    localparam logic [7:0] COM_SYM_DEFAULT = 8'hBC;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_COUNT  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_LOST   = 2'd3
    } align_state_e;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at MAX instead of wrapping; clear wins over enable.
module sat_counter #(
    parameter int              WIDTH = 4,
    parameter logic [WIDTH-1:0] MAX  = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != MAX)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/rx_align_ctrl.sv
// Byte-alignment controller: hunts for comma symbols, requests bit slips,
// locks after a run of commas and forwards data bytes while aligned.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_SEARCH | hunting for a comma; slip after MISS_LIMIT misses
// ST_COUNT  | counting consecutive commas toward lock
// ST_ACTIVE | aligned; non-comma bytes forwarded, run length watched
// ST_LOST   | one-cycle drop after too long without a comma
module rx_align_ctrl
    import pcie_phy_pkg::*;
#(
    parameter logic [7:0] COM_SYM    = COM_SYM_DEFAULT,
    parameter int         LOCK_COMS  = 4,
    parameter int         MISS_LIMIT = 8,
    parameter int         MAX_RUN    = 64
) (
    input  logic       clk_4f,
    input  logic       reset,
    input  logic [7:0] byte_in,
    input  logic       byte_strobe,
    input  logic       relock,
    output logic       slip,
    output logic       active,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic [1:0] state_out
);

    localparam int COM_W  = cnt_width(LOCK_COMS);
    localparam int MISS_W = cnt_width(MISS_LIMIT);
    localparam int RUN_W  = cnt_width(MAX_RUN);

    align_state_e state_d, state_q;
    logic         slip_d, slip_q;
    logic         valid_d, valid_q;
    logic [7:0]   data_d, data_q;

    logic              com_clr, com_en;
    logic              miss_clr, miss_en;
    logic              run_clr, run_en;
    logic [COM_W-1:0]  com_cnt;
    logic [MISS_W-1:0] miss_cnt;
    logic [RUN_W-1:0]  run_cnt;
    logic              is_com;

    assign is_com = (byte_in == COM_SYM);

    sat_counter #(.WIDTH(COM_W), .MAX(COM_W'(LOCK_COMS))) u_com_cnt (
        .clk   (clk_4f),
        .reset (reset),
        .clr   (com_clr),
        .en    (com_en),
        .cnt   (com_cnt)
    );

    sat_counter #(.WIDTH(MISS_W), .MAX(MISS_W'(MISS_LIMIT))) u_miss_cnt (
        .clk   (clk_4f),
        .reset (reset),
        .clr   (miss_clr),
        .en    (miss_en),
        .cnt   (miss_cnt)
    );

    sat_counter #(.WIDTH(RUN_W), .MAX(RUN_W'(MAX_RUN))) u_run_cnt (
        .clk   (clk_4f),
        .reset (reset),
        .clr   (run_clr),
        .en    (run_en),
        .cnt   (run_cnt)
    );

    always_comb begin
        state_d  = state_q;
        slip_d   = 1'b0;
        valid_d  = 1'b0;
        data_d   = data_q;
        com_clr  = 1'b0;
        com_en   = 1'b0;
        miss_clr = 1'b0;
        miss_en  = 1'b0;
        run_clr  = 1'b0;
        run_en   = 1'b0;

        if (relock) begin
            // relock discards any coincident byte
            state_d  = ST_SEARCH;
            com_clr  = 1'b1;
            miss_clr = 1'b1;
            run_clr  = 1'b1;
        end else begin
            case (state_q)
                ST_SEARCH: begin
                    if (byte_strobe) begin
                        if (is_com) begin
                            // com_cnt is always zero on entry to SEARCH
                            com_en   = 1'b1;
                            miss_clr = 1'b1;
                            state_d  = (LOCK_COMS <= 1) ? ST_ACTIVE : ST_COUNT;
                        end else if (miss_cnt == MISS_W'(MISS_LIMIT - 1)) begin
                            slip_d   = 1'b1;
                            miss_clr = 1'b1;
                        end else begin
                            miss_en = 1'b1;
                        end
                    end
                end
                ST_COUNT: begin
                    if (byte_strobe) begin
                        if (is_com) begin
                            com_en = 1'b1;
                            if (com_cnt == COM_W'(LOCK_COMS - 1)) begin
                                state_d = ST_ACTIVE;
                            end
                        end else begin
                            com_clr = 1'b1;
                            state_d = ST_SEARCH;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (byte_strobe) begin
                        if (is_com) begin
                            run_clr = 1'b1;
                        end else begin
                            valid_d = 1'b1;
                            data_d  = byte_in;
                            run_en  = 1'b1;
                            if (run_cnt == RUN_W'(MAX_RUN - 1)) begin
                                state_d = ST_LOST;
                            end
                        end
                    end
                end
                ST_LOST: begin
                    state_d  = ST_SEARCH;
                    com_clr  = 1'b1;
                    miss_clr = 1'b1;
                    run_clr  = 1'b1;
                end
                default: begin
                    state_d = ST_SEARCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk_4f) begin
        if (!reset) begin
            state_q <= ST_SEARCH;
            slip_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            slip_q  <= slip_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign slip      = slip_q;
    assign active    = (state_q == ST_ACTIVE);
    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign state_out = state_q;

endmodule
